// File: rtl/alu_sequencer_if.sv
// Purpose: bundles the alu_sequencer request operands and registered result/status.
// Latency: none (wires only).
// Backpressure: requester may assert start at any time; it is taken only while ready=1.
// Ports: start/cb/acc/a/b flow master->slave; ready/done/s/cout/zero/ovf flow slave->master.
interface alu_sequencer_if;
  logic       start;
  logic       cb;
  logic       acc;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       done;
  logic [7:0] s;
  logic       cout;
  logic       zero;
  logic       ovf;

  modport master (
    output start, cb, acc, a, b,
    input  ready, done, s, cout, zero, ovf
  );

  modport slave (
    input  start, cb, acc, a, b,
    output ready, done, s, cout, zero, ovf
  );
endinterface

// File: rtl/alu_sequencer.sv
// Purpose: three-state add/subtract sequencer with registered result, carry, zero and overflow flags.
// Latency: start taken at edge N, result/flags load at edge N+1, done high N+1..N+2, ready again after N+2.
// Backpressure: start is ignored (never queued) while ready=0.
// Ports: clk, rst (async active-high); bus (alu_sequencer_if.slave) carries operands, select bits and results.
module alu_sequencer (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       capture;
  logic       execute;

  // Operands frozen at the capture edge so later input changes cannot disturb the op in flight.
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cb;

  logic [7:0] s_q;
  logic       cout_q;
  logic       zero_q;
  logic       ovf_q;

  logic [7:0] bx;
  logic [8:0] sum;

  // Subtract is A + ~B + 1; bit 8 is then the "no borrow" indication.
  assign bx  = op_b ^ {8{op_cb}};
  assign sum = {1'b0, op_a} + {1'b0, bx} + {8'd0, op_cb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    execute   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_EXEC;
          capture   = 1'b1;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_DONE;
        execute   = 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= 8'd0;
      op_b  <= 8'd0;
      op_cb <= 1'b0;
    end else if (capture) begin
      // Chained mode reuses the last completed result (0 after reset) as A.
      op_a  <= bus.acc ? s_q : bus.a;
      op_b  <= bus.b;
      op_cb <= bus.cb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 8'd0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (execute) begin
      s_q    <= sum[7:0];
      cout_q <= sum[8];
      zero_q <= (sum[7:0] == 8'd0);
      // Signed overflow: operands agree in sign but the result does not.
      ovf_q  <= (op_a[7] == bx[7]) && (sum[7] != op_a[7]);
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.done  = (state == ST_DONE);
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;

endmodule
